// File: rtl/regfile_wb_arbiter.sv
// Shares the register_file write port between the pipeline WB stage and the long-latency unit.
// Latency: grant to rd_write_en_o is 1 cycle; busy bits rise 1 cycle after issue and fall at commit.
// Backpressure: pipeline has absolute priority; the LU is refused via lu_ready_o, and wb_stall_o asks the pipeline to yield.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module regfile_wb_arbiter #(
    parameter int DATA_WIDTH     = `DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH,
    parameter int STARVE_LIMIT   = 4,
    localparam int NREG          = 2 ** REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pipe_we_i,
    input  logic [REG_ADDR_WIDTH-1:0] pipe_rd_i,
    input  logic [DATA_WIDTH-1:0]     pipe_data_i,
    input  logic                      lu_issue_i,
    input  logic [REG_ADDR_WIDTH-1:0] lu_issue_rd_i,
    input  logic                      lu_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] lu_rd_i,
    input  logic [DATA_WIDTH-1:0]     lu_data_i,
    output logic                      lu_ready_o,
    output logic                      rd_write_en_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
    output logic [DATA_WIDTH-1:0]     rd_data_o,
    output logic                      wb_stall_o,
    output logic [NREG-1:0]           busy_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Write-port registers; wr_from_lu_q remembers the source so the scoreboard clears at commit.
    logic                      rd_write_en_q, rd_write_en_d;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0]     rd_data_q, rd_data_d;
    logic                      wr_from_lu_q, wr_from_lu_d;

    // Starvation tracking.
    logic [3:0]                starve_cnt_q, starve_cnt_d;
    logic                      wb_stall_q, wb_stall_d;

    // Scoreboard of registers awaiting a long-latency result.
    logic [NREG-1:0]           busy_q, busy_d;

    logic                      pipe_act;
    logic                      lu_hs;

    // A pipeline write to x0 is a no-op and does not occupy the port.
    assign pipe_act   = pipe_we_i && (pipe_rd_i != '0);
    assign lu_ready_o = !rst && !pipe_act;
    assign lu_hs      = lu_valid_i && lu_ready_o;

    // Grant: pipeline first, then the LU; an idle cycle keeps addr/data stable.
    always_comb begin
        rd_write_en_d = 1'b0;
        rd_addr_d     = rd_addr_q;
        rd_data_d     = rd_data_q;
        wr_from_lu_d  = 1'b0;
        if (pipe_act) begin
            rd_write_en_d = 1'b1;
            rd_addr_d     = pipe_rd_i;
            rd_data_d     = pipe_data_i;
        end else if (lu_hs) begin
            // An LU result for x0 is consumed but never written.
            rd_write_en_d = (lu_rd_i != '0);
            rd_addr_d     = lu_rd_i;
            rd_data_d     = lu_data_i;
            wr_from_lu_d  = 1'b1;
        end
    end

    // Count consecutive refused LU cycles and request a pipeline bubble once the limit is hit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        wb_stall_d   = wb_stall_q;
        if (!lu_valid_i || lu_hs) begin
            starve_cnt_d = 4'd0;
            wb_stall_d   = 1'b0;
        end else begin
            // Here lu_valid_i is high and the result was refused.
            starve_cnt_d = (starve_cnt_q >= LIMIT) ? LIMIT : starve_cnt_q + 4'd1;
            if (starve_cnt_d == LIMIT) begin
                wb_stall_d = 1'b1;
            end
        end
    end

    // Scoreboard update: clear on LU commit, then set on issue so a same-cycle set wins.
    always_comb begin
        busy_d = busy_q;
        if (rd_write_en_q && wr_from_lu_q) begin
            busy_d[rd_addr_q] = 1'b0;
        end
        if (lu_issue_i && (lu_issue_rd_i != '0)) begin
            busy_d[lu_issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers with synchronous reset; a grant pending at reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_write_en_q <= 1'b0;
            rd_addr_q     <= '0;
            rd_data_q     <= '0;
            wr_from_lu_q  <= 1'b0;
            starve_cnt_q  <= 4'd0;
            wb_stall_q    <= 1'b0;
            busy_q        <= '0;
        end else begin
            rd_write_en_q <= rd_write_en_d;
            rd_addr_q     <= rd_addr_d;
            rd_data_q     <= rd_data_d;
            wr_from_lu_q  <= wr_from_lu_d;
            starve_cnt_q  <= starve_cnt_d;
            wb_stall_q    <= wb_stall_d;
            busy_q        <= busy_d;
        end
    end

    assign rd_write_en_o = rd_write_en_q;
    assign rd_addr_o     = rd_addr_q;
    assign rd_data_o     = rd_data_q;
    assign wb_stall_o    = wb_stall_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a behavioural model.
// Latency: outputs compared every cycle at the falling edge; literal checks 1ns after the rising edge.
// Backpressure: LU refusal and stall behaviour predicted from the arbitration rules.

module tb_regfile_wb_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NREG  = 32;
    localparam int LIMIT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            pipe_we;
    logic [AW-1:0]   pipe_rd;
    logic [DW-1:0]   pipe_data;
    logic            lu_issue;
    logic [AW-1:0]   lu_issue_rd;
    logic            lu_valid;
    logic [AW-1:0]   lu_rd;
    logic [DW-1:0]   lu_data;
    logic            lu_ready;
    logic            rd_we;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   rd_data;
    logic            wb_stall;
    logic [NREG-1:0] busy;

    int vectors = 0;
    int errors  = 0;

    // Model state: what the output registers must hold after the last edge.
    bit            m_we;
    bit [AW-1:0]   m_addr;
    bit [DW-1:0]   m_data;
    bit            m_from_lu;
    bit            m_pending [NREG];
    int            m_refused;
    bit            m_stall;
    bit            chk_en = 1'b0;

    regfile_wb_arbiter #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .pipe_we_i(pipe_we), .pipe_rd_i(pipe_rd), .pipe_data_i(pipe_data),
        .lu_issue_i(lu_issue), .lu_issue_rd_i(lu_issue_rd),
        .lu_valid_i(lu_valid), .lu_rd_i(lu_rd), .lu_data_i(lu_data),
        .lu_ready_o(lu_ready),
        .rd_write_en_o(rd_we), .rd_addr_o(rd_addr), .rd_data_o(rd_data),
        .wb_stall_o(wb_stall), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NREG-1:0] model_busy();
        logic [NREG-1:0] v;
        for (int i = 0; i < NREG; i++) v[i] = m_pending[i];
        return v;
    endfunction

    task automatic drive(input logic pwe, input logic [AW-1:0] prd, input logic [DW-1:0] pd,
                         input logic iss, input logic [AW-1:0] ird,
                         input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                         input logic r);
        pipe_we = pwe; pipe_rd = prd; pipe_data = pd;
        lu_issue = iss; lu_issue_rd = ird;
        lu_valid = lv; lu_rd = lrd; lu_data = ld;
        rst = r;
        #1;
    endtask

    // One clock: compare DUT against the model, advance the model by the arbitration rules.
    task automatic tick();
        bit pipe_wins, lu_taken, ready;
        bit n_we, n_from_lu, n_stall;
        bit [AW-1:0] n_addr;
        bit [DW-1:0] n_data;
        bit n_pending [NREG];
        int n_refused;
        @(negedge clk);
        pipe_wins = pipe_we && (pipe_rd != 0);
        ready     = !rst && !pipe_wins;
        lu_taken  = lu_valid && ready;
        if (chk_en) begin
            chk("lu_ready", 64'(lu_ready), 64'(ready));
            chk("rd_we", 64'(rd_we), 64'(m_we));
            chk("rd_addr", 64'(rd_addr), 64'(m_addr));
            chk("rd_data", 64'(rd_data), 64'(m_data));
            chk("wb_stall", 64'(wb_stall), 64'(m_stall));
            chk("busy", 64'(busy), 64'(model_busy()));
        end
        n_pending = m_pending;
        if (rst) begin
            n_we = 0; n_addr = 0; n_data = 0; n_from_lu = 0; n_stall = 0; n_refused = 0;
            for (int i = 0; i < NREG; i++) n_pending[i] = 0;
        end else begin
            n_addr = m_addr; n_data = m_data; n_we = 0; n_from_lu = 0;
            if (pipe_wins) begin
                n_we = 1; n_addr = pipe_rd; n_data = pipe_data;
            end else if (lu_taken) begin
                n_we = (lu_rd != 0); n_addr = lu_rd; n_data = lu_data; n_from_lu = 1;
            end
            // The pending result retires as it is committed to the register file.
            if (m_we && m_from_lu) n_pending[m_addr] = 0;
            if (lu_issue && lu_issue_rd != 0) n_pending[lu_issue_rd] = 1;
            if (lu_valid && !lu_taken) begin
                n_refused = (m_refused + 1 > LIMIT) ? LIMIT : m_refused + 1;
                n_stall   = (n_refused == LIMIT) ? 1'b1 : m_stall;
            end else begin
                n_refused = 0;
                n_stall   = 0;
            end
        end
        @(posedge clk);
        #1;
        m_we = n_we; m_addr = n_addr; m_data = n_data; m_from_lu = n_from_lu;
        m_pending = n_pending; m_refused = n_refused; m_stall = n_stall;
        if (rst) chk_en = 1'b1;
    endtask

    initial begin
        logic [NREG-1:0] busy_snap;
        int pct;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("reset lu_ready", 64'(lu_ready), 64'(0));
        tick();
        chk("reset outputs", {rd_we, wb_stall, 30'(rd_addr)}, 64'(0));
        chk("reset busy", 64'(busy), 64'(0));

        // Solo pipeline write.
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        tick();
        chk("solo we", 64'(rd_we), 64'(1));
        chk("solo addr", 64'(rd_addr), 64'(5));
        chk("solo data", 64'(rd_data), 64'hDEADBEEF);

        // Contention: pipe wins, LU follows next cycle.
        drive(1, 3, 32'h33, 0, 0, 1, 7, 32'h11, 0);
        chk("contend ready", 64'(lu_ready), 64'(0));
        tick();
        chk("contend pipe addr", 64'(rd_addr), 64'(3));
        drive(0, 0, 0, 0, 0, 1, 7, 32'h11, 0);
        chk("contend lu ready", 64'(lu_ready), 64'(1));
        tick();
        chk("contend lu write", {rd_we, 27'(rd_addr), rd_data}, {1'b1, 27'd7, 32'h11});

        // Starvation at limit 4.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 32'(i), 0, 0, 1, 2, 32'h22, 0);
            tick();
            if (i == 2) chk("starve after 3", 64'(wb_stall), 64'(0));
        end
        chk("starve after 4", 64'(wb_stall), 64'(1));
        drive(0, 0, 0, 0, 0, 1, 2, 32'h22, 0);
        tick();
        chk("starve release", {wb_stall, rd_we, 5'(rd_addr)}, {1'b0, 1'b1, 5'd2});

        // Scoreboard.
        drive(0, 0, 0, 1, 9, 0, 0, 0, 0);
        tick();
        chk("busy9 set", 64'(busy[9]), 64'(1));
        drive(0, 0, 0, 0, 0, 1, 9, 32'h99, 0);
        tick();
        chk("busy9 during commit", 64'(busy[9]), 64'(1));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("busy9 cleared", 64'(busy[9]), 64'(0));
        drive(0, 0, 0, 1, 9, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 9, 32'h98, 0);
        tick();
        drive(0, 0, 0, 1, 9, 0, 0, 0, 0);
        tick();
        chk("busy9 set wins", 64'(busy[9]), 64'(1));
        busy_snap = busy;
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
        tick();
        chk("issue x0", 64'(busy), 64'(busy_snap));

        // x0 handling.
        drive(1, 0, 32'h55, 0, 0, 1, 4, 32'h44, 0);
        chk("pipe x0 ready", 64'(lu_ready), 64'(1));
        tick();
        chk("pipe x0 lu write", {rd_we, 5'(rd_addr)}, {1'b1, 5'd4});
        drive(0, 0, 0, 0, 0, 1, 0, 32'h77, 0);
        chk("lu x0 ready", 64'(lu_ready), 64'(1));
        tick();
        chk("lu x0 no write", 64'(rd_we), 64'(0));

        // Reset right after a grant with busy bits set.
        drive(0, 0, 0, 1, 12, 0, 0, 0, 0);
        tick();
        drive(1, 8, 32'h88, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 8, 32'h89, 0, 0, 1, 6, 32'h66, 1);
        chk("mid reset ready", 64'(lu_ready), 64'(0));
        tick();
        chk("mid reset outputs", {rd_we, wb_stall, 5'(rd_addr), 32'(rd_data)}, 64'(0));
        chk("mid reset busy", 64'(busy), 64'(0));

        // Randomized traffic with shifting pipeline load.
        pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) pct = (c / 100) % 3 == 0 ? 20 : ((c / 100) % 3 == 1 ? 60 : 95);
            drive($urandom_range(99) < pct,
                  ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom),
                  $urandom,
                  $urandom_range(99) < 30,
                  ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom),
                  $urandom_range(99) < 60,
                  ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom),
                  $urandom,
                  $urandom_range(199) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard in front of the single write port of `register_file`. It shares that port between two sources:
- the in-order pipeline WB stage, which has fixed priority and no backpressure;
- a long-latency unit (MUL/DIV) that uses a valid/ready handshake.

It tracks destination registers with in-flight long-latency results (busy bitmap for the hazard unit) and forces a WB bubble when the long-latency unit starves. Outputs drive `rd_write_en_wb_i` / `rd_addr_wb_i` / `rd_data_wb_i` of `register_file` directly.

## Interface
Parameters:
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (32): write data width.
- `REG_ADDR_WIDTH`, default `` `REG_ADDR_WIDTH `` (5): register index width. `NREG = 2**REG_ADDR_WIDTH`.
- `STARVE_LIMIT`, default 4: consecutive refused long-latency cycles before a WB stall is forced. Legal range 1..15.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `pipe_we_i`  in  1  pipeline WB write request.
- `pipe_rd_i`  in  REG_ADDR_WIDTH  pipeline destination register.
- `pipe_data_i`  in  DATA_WIDTH  pipeline write data.
- `lu_issue_i`  in  1  long-latency op issued this cycle.
- `lu_issue_rd_i`  in  REG_ADDR_WIDTH  destination register of the issued op.
- `lu_valid_i`  in  1  long-latency result available.
- `lu_rd_i`  in  REG_ADDR_WIDTH  result destination register.
- `lu_data_i`  in  DATA_WIDTH  result data.
- `lu_ready_o`  out  1  result accepted this cycle (combinational).
- `rd_write_en_o`  out  1  register_file write enable (registered).
- `rd_addr_o`  out  REG_ADDR_WIDTH  register_file write address (registered).
- `rd_data_o`  out  DATA_WIDTH  register_file write data (registered).
- `wb_stall_o`  out  1  pipeline must present `pipe_we_i=0` next cycle (registered).
- `busy_o`  out  NREG  scoreboard; bit r=1 means a long-latency result for xr is pending.

## Operation
- **pipe_act:** `pipe_act = pipe_we_i && pipe_rd_i != 0`. A pipeline write to x0 is dropped and leaves the slot free.
- **lu_ready_o:** `lu_ready_o = !rst && !pipe_act`. Handshake `lu_hs = lu_valid_i && lu_ready_o`.
- **Grant:**
  - pipe_act: register pipe rd/data with `rd_write_en_o <= 1`.
  - Else if lu_hs: register lu rd/data with `rd_write_en_o <= (lu_rd_i != 0)`. An lu result to x0 is accepted but not written.
  - Else: `rd_write_en_o <= 0`. Addr/data hold their previous values.
- **Pipeline priority is absolute.** `wb_stall_o` is a request only. If the pipeline ignores it, pipe still wins and the stall stays asserted.
- **Starvation counter** (4 bits):
  - Clears when `!lu_valid_i` or on lu_hs.
  - Increments when `lu_valid_i && !lu_ready_o`, saturating at `STARVE_LIMIT`.
  - `wb_stall_o <= 1` when next-count == `STARVE_LIMIT`.
  - `wb_stall_o <= 0` on lu_hs or when `!lu_valid_i`.
- **Scoreboard:**
  - Set `busy[lu_issue_rd_i]` on `lu_issue_i` with rd != 0.
  - Clear `busy[rd_addr_o]` in the cycle where `rd_write_en_o=1` and that write came from lu. The clear is therefore aligned with the register_file commit edge.
  - Set and clear of the same bit in one cycle: set wins.
  - `busy_o[0]` is constant 0.
  - Pipeline writes never modify busy.
- **Reset:** `rst` clears all registered outputs (`rd_write_en_o`, `rd_addr_o`, `rd_data_o` = 0), `wb_stall_o`=0, `busy_o`=0 and the counter. A grant pending at reset is discarded.

## Timing
- Grant to `rd_write_en_o`: 1 cycle. Write is visible on register_file reads 2 edges after the grant edge.
- Busy bit: rises 1 cycle after `lu_issue_i`. Falls on the edge ending the cycle where the lu write is on the output registers.
- `wb_stall_o` rises 1 cycle after the refused-cycle count reaches `STARVE_LIMIT`. Falls 1 cycle after lu_hs.
- Throughput: 1 write per cycle. Never 2 writes in one cycle.
- `lu_ready_o` is combinational from `pipe_we_i`/`pipe_rd_i`. There is no combinational path from `lu_valid_i` to any output.

## Test plan
- **Solo pipe write.** Pipe we=1, rd=5, data=0xDEADBEEF at cycle 0 -> cycle 1 `rd_write_en_o=1`, addr=5, data=0xDEADBEEF. Readback through register_file x5=0xDEADBEEF.
- **Contention.** Pipe we=1 rd=3 and lu valid rd=7 data=0x11 in the same cycle -> `lu_ready_o=0`, pipe written. Next cycle pipe idle -> lu_hs, x7=0x11 one cycle later.
- **Starvation, STARVE_LIMIT=4.** lu valid held with pipe_act=1 every cycle -> `wb_stall_o=1` after 4 refused cycles. Pipe drops we -> lu_hs; `wb_stall_o=0` next cycle; counter 0.
- **Scoreboard.** Issue rd=9 -> `busy_o[9]=1` next cycle. Result handshake -> bit clears on the commit edge. Issue rd=9 in the same cycle as the retire of rd=9 -> bit stays 1. Issue rd=0 -> `busy_o` unchanged.
- **x0 handling.** Pipe we=1 rd=0 -> no write, and lu rd=4 is accepted that same cycle. Lu result rd=0 -> `lu_ready_o=1`, `rd_write_en_o=0`.
- **Reset mid-operation.** Assert `rst` in the cycle after a grant with busy bits set -> next cycle all outputs 0, `busy_o=0`, `lu_ready_o=0` while `rst`=1.
